// File: rtl/sram_if_pkg.sv
// rtl/sram_if_pkg.sv - shared state encoding and timing defaults for the async SRAM master
package sram_if_pkg;

    localparam int DEF_DATA_WIDTH = 8;
    localparam int DEF_ADDR_WIDTH = 10;
    localparam int DEF_RD_WAIT    = 2;
    localparam int DEF_WR_PULSE   = 2;

    localparam logic [2:0] ST_IDLE      = 3'd0;
    localparam logic [2:0] ST_SETUP     = 3'd1;
    localparam logic [2:0] ST_RD_STROBE = 3'd2;
    localparam logic [2:0] ST_WR_STROBE = 3'd3;
    localparam logic [2:0] ST_HOLD      = 3'd4;

    // Counter counts down to zero, so a strobe of N cycles loads N-1.
    function automatic logic [3:0] strobe_reload(input int cycles);
        return 4'(cycles - 1);
    endfunction

endpackage

// File: rtl/sram_async_master.sv
// rtl/sram_async_master.sv - single-port async SRAM master: SETUP, timed OE/WE strobe, HOLD
module sram_async_master
    import sram_if_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int RD_WAIT    = DEF_RD_WAIT,
    parameter int WR_PULSE   = DEF_WR_PULSE
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req,
    input  logic                  we,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [DATA_WIDTH-1:0] wdata,
    output logic                  busy,
    output logic                  ack,
    output logic [DATA_WIDTH-1:0] rdata,
    output logic [ADDR_WIDTH-1:0] sram_addr,
    output logic                  sram_ce1n,
    output logic                  sram_ce2,
    output logic                  sram_oen,
    output logic                  sram_wen,
    output logic [DATA_WIDTH-1:0] sram_dout,
    output logic                  sram_doe,
    input  logic [DATA_WIDTH-1:0] sram_din
);

    localparam logic [3:0] RD_RELOAD = strobe_reload(RD_WAIT);
    localparam logic [3:0] WR_RELOAD = strobe_reload(WR_PULSE);

    logic [2:0]            state_q, state_d;
    logic [3:0]            cnt_q, cnt_d;
    logic                  we_q, we_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [DATA_WIDTH-1:0] dout_q, dout_d;
    logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
    logic                  ce1n_q, ce1n_d;
    logic                  ce2_q, ce2_d;
    logic                  oen_q, oen_d;
    logic                  wen_q, wen_d;
    logic                  doe_q, doe_d;

    // Pin values are computed for the next state and registered, so the SRAM never sees req directly.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        we_d    = we_q;
        addr_d  = addr_q;
        dout_d  = dout_q;
        rdata_d = rdata_q;
        ce1n_d  = ce1n_q;
        ce2_d   = ce2_q;
        oen_d   = oen_q;
        wen_d   = wen_q;
        doe_d   = doe_q;
        case (state_q)
            ST_IDLE: begin
                if (req) begin
                    state_d = ST_SETUP;
                    we_d    = we;
                    addr_d  = addr;
                    ce1n_d  = 1'b0;
                    ce2_d   = 1'b1;
                    doe_d   = we;
                    if (we) begin
                        dout_d = wdata;
                    end
                end
            end
            ST_SETUP: begin
                if (we_q) begin
                    state_d = ST_WR_STROBE;
                    wen_d   = 1'b0;
                    cnt_d   = WR_RELOAD;
                end else begin
                    state_d = ST_RD_STROBE;
                    oen_d   = 1'b0;
                    cnt_d   = RD_RELOAD;
                end
            end
            ST_RD_STROBE: begin
                if (cnt_q == 4'd0) begin
                    state_d = ST_HOLD;
                    oen_d   = 1'b1;
                    rdata_d = sram_din;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            ST_WR_STROBE: begin
                if (cnt_q == 4'd0) begin
                    state_d = ST_HOLD;
                    wen_d   = 1'b1;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            ST_HOLD: begin
                state_d = ST_IDLE;
                ce1n_d  = 1'b1;
                ce2_d   = 1'b0;
                doe_d   = 1'b0;
            end
            default: begin
                state_d = ST_IDLE;
                ce1n_d  = 1'b1;
                ce2_d   = 1'b0;
                oen_d   = 1'b1;
                wen_d   = 1'b1;
                doe_d   = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= 4'd0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            dout_q  <= '0;
            rdata_q <= '0;
            ce1n_q  <= 1'b1;
            ce2_q   <= 1'b0;
            oen_q   <= 1'b1;
            wen_q   <= 1'b1;
            doe_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            dout_q  <= dout_d;
            rdata_q <= rdata_d;
            ce1n_q  <= ce1n_d;
            ce2_q   <= ce2_d;
            oen_q   <= oen_d;
            wen_q   <= wen_d;
            doe_q   <= doe_d;
        end
    end

    assign busy      = (state_q != ST_IDLE);
    assign ack       = (state_q == ST_HOLD);
    assign rdata     = rdata_q;
    assign sram_addr = addr_q;
    assign sram_ce1n = ce1n_q;
    assign sram_ce2  = ce2_q;
    assign sram_oen  = oen_q;
    assign sram_wen  = wen_q;
    assign sram_dout = dout_q;
    assign sram_doe  = doe_q;

endmodule

// File: tb/tb_sram_async_master.sv
// tb/tb_sram_async_master.sv - random and directed accesses against a 1Kx8 async SRAM model and reference memory
module tb_sram_async_master;

    logic       clk = 1'b0;
    logic       rst;
    logic       req, we, sel;
    logic [9:0] addr;
    logic [7:0] wdata;

    logic       busy_a, ack_a, ce1n_a, ce2_a, oen_a, wen_a, doe_a;
    logic [7:0] rdata_a, dout_a;
    logic [9:0] saddr_a;
    logic       busy_b, ack_b, ce1n_b, ce2_b, oen_b, wen_b, doe_b;
    logic [7:0] rdata_b, dout_b;
    logic [9:0] saddr_b;

    logic       busy, ack, s_ce1n, s_ce2, s_oen, s_wen, s_doe;
    logic [7:0] rdata, s_dout, sram_din;
    logic [9:0] s_addr;

    logic [7:0] mem     [0:1023] = '{default: 8'h00};
    logic [7:0] ref_mem [0:1023] = '{default: 8'h00};
    logic [7:0] last_rd [0:1]    = '{default: 8'h00};

    int vectors    = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    sram_async_master u_dut_a (
        .clk(clk), .rst(rst), .req(req & ~sel), .we(we), .addr(addr), .wdata(wdata),
        .busy(busy_a), .ack(ack_a), .rdata(rdata_a), .sram_addr(saddr_a),
        .sram_ce1n(ce1n_a), .sram_ce2(ce2_a), .sram_oen(oen_a), .sram_wen(wen_a),
        .sram_dout(dout_a), .sram_doe(doe_a), .sram_din(sram_din)
    );

    sram_async_master #(.RD_WAIT(5), .WR_PULSE(1)) u_dut_b (
        .clk(clk), .rst(rst), .req(req & sel), .we(we), .addr(addr), .wdata(wdata),
        .busy(busy_b), .ack(ack_b), .rdata(rdata_b), .sram_addr(saddr_b),
        .sram_ce1n(ce1n_b), .sram_ce2(ce2_b), .sram_oen(oen_b), .sram_wen(wen_b),
        .sram_dout(dout_b), .sram_doe(doe_b), .sram_din(sram_din)
    );

    assign busy   = sel ? busy_b  : busy_a;
    assign ack    = sel ? ack_b   : ack_a;
    assign rdata  = sel ? rdata_b : rdata_a;
    assign s_addr = sel ? saddr_b : saddr_a;
    assign s_ce1n = sel ? ce1n_b  : ce1n_a;
    assign s_ce2  = sel ? ce2_b   : ce2_a;
    assign s_oen  = sel ? oen_b   : oen_a;
    assign s_wen  = sel ? wen_b   : wen_a;
    assign s_dout = sel ? dout_b  : dout_a;
    assign s_doe  = sel ? doe_b   : doe_a;

    // Async SRAM: data visible while selected and output-enabled, write commits on WEn rising.
    assign sram_din = (!s_ce1n && s_ce2 && !s_oen) ? mem[s_addr] : 8'hEE;

    always @(posedge s_wen) begin
        if (!rst && !s_ce1n && s_ce2) begin
            mem[s_addr] <= s_dout;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic check_idle_pins(input string tag);
        check(tag, 32'({busy, ack, s_ce1n, s_ce2, s_oen, s_wen, s_doe}), 32'b0010110);
    endtask

    // Called at a falling edge with the selected DUT idle; returns at the falling edge of the idle gap.
    task automatic do_access(input bit w, input logic [9:0] a, input logic [7:0] d, input bit hold_req);
        int n;
        int cyc;
        int oen_low;
        int wen_low;
        bit got_ack;
        n = w ? (sel ? 1 : 2) : (sel ? 5 : 2);
        check("start_busy", 32'(busy), 32'd0);
        req = 1'b1; we = w; addr = a; wdata = d;
        @(posedge clk);
        @(negedge clk);
        req = hold_req; we = 1'($urandom); addr = 10'($urandom); wdata = 8'($urandom);
        cyc = 1; oen_low = 0; wen_low = 0; got_ack = 1'b0;
        while (!got_ack && cyc < 40) begin
            if (!s_oen) oen_low++;
            if (!s_wen) wen_low++;
            check("busy", 32'(busy), 32'd1);
            check("ce_active", 32'({s_ce1n, s_ce2}), 32'b01);
            check("addr_stable", 32'(s_addr), 32'(a));
            check("doe_dir", 32'(s_doe), 32'(w));
            check("doe_oen_excl", 32'(s_doe & ~s_oen), 32'd0);
            if (w) check("dout", 32'(s_dout), 32'(d));
            if (ack) begin
                got_ack = 1'b1;
            end else begin
                @(negedge clk);
                cyc++;
                we = 1'($urandom); addr = 10'($urandom); wdata = 8'($urandom);
            end
        end
        check("ack_latency", 32'(cyc), 32'(n + 2));
        check("oen_low_cycles", 32'(oen_low), 32'(w ? 0 : n));
        check("wen_low_cycles", 32'(wen_low), 32'(w ? n : 0));
        if (w) begin
            ref_mem[a] = d;
            check("rdata_held", 32'(rdata), 32'(last_rd[sel]));
        end else begin
            check("rdata", 32'(rdata), 32'(ref_mem[a]));
            last_rd[sel] = ref_mem[a];
        end
        @(negedge clk);
        check_idle_pins("gap_pins");
    endtask

    initial begin
        rst = 1'b1; req = 1'b0; we = 1'b0; addr = '0; wdata = '0; sel = 1'b0;
        repeat (2) @(negedge clk);
        check_idle_pins("reset_pins");
        check("reset_addr_rdata", 32'({s_addr, rdata, s_dout}), 32'd0);
        check("reset_b", 32'({busy_b, ack_b, ce1n_b, oen_b, wen_b, doe_b}), 32'b001110);
        rst = 1'b0;
        @(negedge clk);

        do_access(1'b1, 10'h3A5, 8'h5C, 1'b0);
        do_access(1'b0, 10'h3A5, 8'h00, 1'b0);

        do_access(1'b1, 10'h000, 8'hA1, 1'b1);
        do_access(1'b0, 10'h000, 8'h00, 1'b1);
        do_access(1'b1, 10'h3FF, 8'h7E, 1'b1);
        do_access(1'b0, 10'h3FF, 8'h00, 1'b0);

        // Abort a write in its second strobe cycle; the old contents must survive.
        do_access(1'b1, 10'h155, 8'h33, 1'b0);
        req = 1'b1; we = 1'b1; addr = 10'h155; wdata = 8'hCC;
        @(posedge clk);
        @(negedge clk);
        req = 1'b0;
        @(negedge clk);
        check("abort_wen_1st", 32'(s_wen), 32'd0);
        @(negedge clk);
        check("abort_wen_2nd", 32'(s_wen), 32'd0);
        #1 rst = 1'b1;
        #1;
        check_idle_pins("abort_pins");
        check("abort_addr_rdata_dout", 32'({s_addr, rdata, s_dout}), 32'd0);
        last_rd[0] = 8'h00;
        last_rd[1] = 8'h00;
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("abort_no_ack", 32'({ack, busy}), 32'd0);
        end
        do_access(1'b0, 10'h155, 8'h00, 1'b0);

        sel = 1'b1;
        @(negedge clk);
        do_access(1'b1, 10'h2AA, 8'h96, 1'b0);
        do_access(1'b0, 10'h2AA, 8'h00, 1'b0);

        for (int i = 0; i < 60; i++) begin
            bit w;
            bit h;
            logic [9:0] a;
            sel = 1'($urandom);
            w = 1'($urandom);
            h = (i < 59) && ($urandom_range(0, 2) == 0);
            a = $urandom_range(0, 1) ? 10'($urandom_range(0, 15)) : 10'($urandom);
            do_access(w, a, 8'($urandom), h);
            if (!h) repeat ($urandom_range(0, 2)) @(negedge clk);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/sram_async_master.md
SRAM_ASYNC_MASTER -- requirements
Module: sram_async_master

Interface
REQ-001 The block SHALL use one clock, and its reset SHALL be asynchronous and active-high; the ports are named clk and rst.
REQ-002 Parameter DATA_WIDTH, default 8: data bus width.
REQ-003 Parameter ADDR_WIDTH, default 10: address width.
REQ-004 Parameter RD_WAIT, default 2: cycles OEn is held low before the read data is sampled (range 1..15).
REQ-005 Parameter WR_PULSE, default 2: cycles WEn is held low (range 1..15).
REQ-006 Port list, one per line: name, direction, width, meaning.
- clk, in, 1: system clock.
- rst, in, 1: asynchronous active-high reset.
- req, in, 1: access request, level, sampled in IDLE.
- we, in, 1: 1 = write, 0 = read; qualified by req.
- addr, in, ADDR_WIDTH: access address.
- wdata, in, DATA_WIDTH: write data.
- busy, out, 1: high while not in IDLE.
- ack, out, 1: one-cycle completion pulse.
- rdata, out, DATA_WIDTH: read result; valid with ack and held until the next read completes.
- sram_addr, out, ADDR_WIDTH: SRAM address.
- sram_ce1n, out, 1: chip enable, active low.
- sram_ce2, out, 1: chip enable, active high.
- sram_oen, out, 1: output enable, active low.
- sram_wen, out, 1: write enable, active low.
- sram_dout, out, DATA_WIDTH: data driven to the SRAM.
- sram_doe, out, 1: tristate enable for sram_dout; the top level builds the inout.
- sram_din, in, DATA_WIDTH: data returned from the SRAM.

Function
REQ-007 The FSM SHALL have the states IDLE, SETUP, RD_STROBE, WR_STROBE, HOLD.
REQ-008 In IDLE with req=1, the block SHALL register addr, we and wdata and go to SETUP; with req=0 it SHALL stay in IDLE.
REQ-009 SETUP SHALL last 1 cycle:
- CE is asserted (ce1n=0, ce2=1) and sram_addr is stable.
- OEn=1 and WEn=1.
- For a write, sram_doe=1.
- Next state is RD_STROBE or WR_STROBE.
REQ-010 RD_STROBE SHALL hold OEn=0 for exactly RD_WAIT cycles, then capture sram_din into rdata on the last cycle and go to HOLD.
REQ-011 WR_STROBE SHALL hold WEn=0 for exactly WR_PULSE cycles, with sram_doe=1 and sram_dout equal to the latched wdata, then go to HOLD.
REQ-012 HOLD SHALL last 1 cycle:
- OEn and WEn are deasserted (=1).
- CE and sram_addr are unchanged.
- For a write, sram_doe remains 1 so data is held past the WEn rising edge.
- ack=1 for this cycle; next state is IDLE.
REQ-013 In IDLE, CE SHALL be deasserted, with OEn=1, WEn=1 and sram_doe=0.
REQ-014 sram_doe and sram_oen SHALL never both be active in the same cycle; sram_wen=0 SHALL imply sram_doe=1.
REQ-015 All SRAM-side outputs SHALL be driven from registers; there SHALL be no combinational path from req to the SRAM pins.
REQ-016 The strobe counter SHALL be 4 bits and reload on entry to each strobe state; no wrap-around is permitted within one access.
REQ-017 Back-to-back accesses: req held high SHALL start a new access in the cycle after HOLD. Total latency per access is 1 + RD_WAIT + 1 (read) or 1 + WR_PULSE + 1 (write) cycles from leaving IDLE, plus the 1-cycle IDLE gap.
REQ-018 Changes on req, addr, we or wdata while busy=1 SHALL be ignored.

Reset
REQ-019 Asserting rst at any time, including mid-strobe, SHALL immediately force the following values:
- state = IDLE, busy = 0, ack = 0.
- rdata = 0, sram_addr = 0.
- sram_ce1n = 1, sram_ce2 = 0.
- sram_oen = 1, sram_wen = 1.
- sram_doe = 0, sram_dout = 0.
REQ-020 An access aborted by reset SHALL NOT produce ack.

Structure
REQ-021 The state encoding and the default timing constants SHALL live in a shared package, sram_if_pkg.
REQ-022 The block SHALL be a single module with no sub-modules.

Verification
REQ-023 The bench SHALL pair the block with a behavioural async SRAM model of 1K x 8 and cover these directed scenarios:
- Write 0x3A5 <- 0x5C, then read 0x3A5 -> rdata = 0x5C with ack; WEn low exactly 2 cycles, OEn low exactly 2 cycles.
- req held high for 4 alternating writes/reads at 0x000 and 0x3FF -> 4 acks, each ack followed by a 1-cycle IDLE gap, all data correct.
- rst asserted during the 2nd WR_STROBE cycle -> all strobes inactive immediately, no ack; a following read of the same address succeeds.
- RD_WAIT=5, WR_PULSE=1 -> OEn low 5 cycles, WEn low 1 cycle, read latency 7 cycles.
- Toggle addr and wdata while busy -> the SRAM sees only the latched values.
- Assertion check throughout every run: never sram_doe=1 with sram_oen=0; sram_addr is stable while OEn or WEn is low.
